// File: rtl/sha_blk_pkg.sv
// Shared types and framing helpers for the SHA block sequencer and related loaders.
package sha_blk_pkg;

  localparam int SHA256_BLOCK_BITS = 512;
  localparam int SHA512_BLOCK_BITS = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic int blk_bytes(input int block_bits);
    return block_bits / 8;
  endfunction

  // Width of the trailing message-length field in bytes (8 for SHA-256, 16 for SHA-512).
  function automatic int len_bytes(input int block_bits);
    return block_bits / 64;
  endfunction

endpackage

// File: rtl/sha_block_sequencer_blk_count_calc.sv
// Combinational padded-block count: nb = ceil((size + 1 + LEN_BYTES) / BB), with overflow flag.
module blk_count_calc
  import sha_blk_pkg::*;
#(
  parameter int BLOCK_BITS = SHA256_BLOCK_BITS,
  parameter int SIZE_W     = 32,
  parameter int CNT_W      = 8
) (
  input  logic [SIZE_W-1:0] size,
  output logic [CNT_W-1:0]  nb,
  output logic              ovf
);

  localparam int BB = blk_bytes(BLOCK_BITS);
  localparam int LB = len_bytes(BLOCK_BITS);
  localparam int W  = SIZE_W + 2;
  localparam int SH = $clog2(BB);

  logic [W-1:0] total;
  logic [W-1:0] nb_full;

  // The 0x80 byte plus the rounding term BB-1 fold into a single +BB; W bits cannot wrap.
  assign total   = W'(size) + W'(LB + BB);
  assign nb_full = total >> SH;
  assign nb      = nb_full[CNT_W-1:0];
  assign ovf     = |nb_full[W-1:CNT_W];

endmodule

// File: rtl/sha_block_sequencer.sv
// Accepts a message length, computes SHA padded block count, emits one descriptor per block.
// Optional abort input enabled by defining SHA_BLKSEQ_ABORT_EN.
module sha_block_sequencer
  import sha_blk_pkg::*;
#(
  parameter int BLOCK_BITS = SHA256_BLOCK_BITS,
  parameter int SIZE_W     = 32,
  parameter int CNT_W      = 8,
  localparam int BB        = blk_bytes(BLOCK_BITS),
  localparam int BBW       = $clog2(BB)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SHA_BLKSEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SIZE_W-1:0] req_size,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [CNT_W-1:0]  blk_idx,
  output logic              blk_last,
  output logic [BBW:0]      blk_data_bytes,
  output logic              blk_pad_here,
  output logic [BBW-1:0]    blk_pad_pos,
  output logic [CNT_W-1:0]  num_blocks,
  output logic              busy,
  output logic              err_ovf
);

  localparam int BW = SIZE_W + 2;

  state_t            state_reg;
  logic [SIZE_W-1:0] size_reg;
  logic [BW-1:0]     base_reg;

  logic [CNT_W-1:0]  calc_nb;
  logic              calc_ovf;
  logic              abort_hit;

  blk_count_calc #(
    .BLOCK_BITS(BLOCK_BITS),
    .SIZE_W    (SIZE_W),
    .CNT_W     (CNT_W)
  ) u_calc (
    .size(size_reg),
    .nb  (calc_nb),
    .ovf (calc_ovf)
  );

`ifdef SHA_BLKSEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Descriptor for the block presented after the next edge: block 0 from CALC, idx+1 from EMIT.
  logic [BW-1:0]    size_ext;
  logic [BW-1:0]    next_base;
  logic [BW-1:0]    rem;
  logic [CNT_W-1:0] next_idx;
  logic [CNT_W-1:0] nb_sel;
  logic [BBW:0]     next_data;
  logic             next_pad_here;
  logic [BBW-1:0]   next_pad_pos;
  logic             next_last;

  always_comb begin
    size_ext      = BW'(size_reg);
    next_base     = '0;
    next_idx      = '0;
    nb_sel        = calc_nb;
    next_data     = '0;
    next_pad_here = 1'b0;
    next_pad_pos  = '0;
    if (state_reg == EMIT) begin
      next_base = base_reg + BW'(BB);
      next_idx  = blk_idx + 1'b1;
      nb_sel    = num_blocks;
    end
    rem = size_ext - next_base;
    if (size_ext >= next_base) begin
      if (rem >= BW'(BB)) begin
        next_data = (BBW+1)'(BB);
      end else begin
        next_data     = rem[BBW:0];
        next_pad_here = 1'b1;
        next_pad_pos  = size_reg[BBW-1:0];
      end
    end
    next_last = (next_idx == nb_sel - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      size_reg       <= '0;
      base_reg       <= '0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      blk_valid      <= 1'b0;
      blk_idx        <= '0;
      blk_last       <= 1'b0;
      blk_data_bytes <= '0;
      blk_pad_here   <= 1'b0;
      blk_pad_pos    <= '0;
      num_blocks     <= '0;
      err_ovf        <= 1'b0;
    end else begin
      err_ovf <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            size_reg   <= req_size;
            num_blocks <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          if (abort_hit || calc_ovf) begin
            err_ovf   <= !abort_hit;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            num_blocks     <= calc_nb;
            base_reg       <= next_base;
            blk_idx        <= next_idx;
            blk_last       <= next_last;
            blk_data_bytes <= next_data;
            blk_pad_here   <= next_pad_here;
            blk_pad_pos    <= next_pad_pos;
            blk_valid      <= 1'b1;
            state_reg      <= EMIT;
          end
        end
        EMIT: begin
          if (abort_hit || (blk_ready && blk_last)) begin
            blk_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (blk_ready) begin
            base_reg       <= next_base;
            blk_idx        <= next_idx;
            blk_last       <= next_last;
            blk_data_bytes <= next_data;
            blk_pad_here   <= next_pad_here;
            blk_pad_pos    <= next_pad_pos;
          end
        end
        default: begin
          blk_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sha_block_sequencer.md
Name: sha_block_sequencer

Overview:
- Parametrised successor to the combinational block-count logic.
- Accepts a message byte length over a valid/ready handshake and computes the padded block count for SHA-256 (512-bit) or SHA-512 (1024-bit) framing.
- Then emits one descriptor per block under backpressure: index, message-byte count, pad-byte location, last flag.
- Sits between the host/message loader and the hash core's block fetch and padding logic.

Parameters:
- BLOCK_BITS, 512, block size in bits; legal values 512 or 1024. Derived: BB = BLOCK_BITS/8; LEN_BYTES = BB/8 (8 or 16).
- SIZE_W, 32, width of the message byte length.
- CNT_W, 8, width of the block count and block index.

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_size  in  SIZE_W  message length in bytes.
- blk_valid  out  1  descriptor valid.
- blk_ready  in  1  consumer accepts descriptor.
- blk_idx  out  CNT_W  block index, 0..num_blocks-1.
- blk_last  out  1  final block; it always carries the length field.
- blk_data_bytes  out  $clog2(BB)+1  message bytes in this block, 0..BB.
- blk_pad_here  out  1  the 0x80 byte lies in this block.
- blk_pad_pos  out  $clog2(BB)  byte offset of 0x80; 0 when blk_pad_here=0.
- num_blocks  out  CNT_W  registered count for the current request.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_ovf  out  1  one-cycle pulse: count exceeds 2^CNT_W-1.

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM in IDLE. Reset mid-operation abandons the request; no further descriptors are emitted.
- FSM IDLE -> CALC -> EMIT -> IDLE.
  - IDLE: on req_valid&&req_ready, register req_size and go to CALC.
  - CALC (exactly 1 cycle):
    - nb = ceil((size + 1 + LEN_BYTES)/BB), computed in SIZE_W+2 bits so there is no wrap near 2^SIZE_W.
    - If nb > 2^CNT_W-1: pulse err_ovf, leave num_blocks at 0, go to IDLE, emit no descriptors.
    - Otherwise register num_blocks and go to EMIT with blk_idx=0.
  - EMIT:
    - blk_valid=1; descriptor fields are stable while blk_valid&&!blk_ready.
    - On handshake with blk_last=1, go to IDLE; otherwise increment blk_idx.
- Latency: request accepted at edge N; num_blocks valid after edge N+1; first blk_valid after edge N+1. With blk_ready tied high, one descriptor per cycle and a return to IDLE after the last handshake. A new request can be accepted the cycle after.
- Descriptor i, with base = i*BB:
  - blk_data_bytes = clamp(size - base, 0, BB).
  - blk_pad_here = (base <= size < base+BB); blk_pad_pos = size mod BB.
  - blk_last = (i == nb-1).
- Boundary: when size mod BB > BB-1-LEN_BYTES, the pad byte sits in block nb-2. The last block then has data_bytes=0 and pad_here=0.
- Boundary: size exact multiple of BB puts the pad at pos 0 of the block after the data.
- req_valid in any state other than IDLE is ignored; req_ready=0 there.
- blk_ready while blk_valid=0 is ignored.

Optional Feature:
- Macro: SHA_BLKSEQ_ABORT_EN.
- With the macro defined: adds input abort (1 bit). abort=1 in CALC or EMIT forces IDLE at the next edge. In that cycle blk_valid drops, no err_ovf, and num_blocks is kept. abort has priority over a simultaneous handshake; the handshake does not count. abort in IDLE has no effect.
- Without it: no abort port; only reset terminates a sequence.

Decomposition:
- Shared package sha_blk_pkg holds:
  - state enum {IDLE, CALC, EMIT};
  - functions blk_bytes(BLOCK_BITS) and len_bytes(BLOCK_BITS);
  - constants SHA256_BLOCK_BITS=512 and SHA512_BLOCK_BITS=1024.
- One combinational sub-module, blk_count_calc: size -> nb plus overflow flag. It is reused by other loaders.
- The per-block descriptor arithmetic stays in the top module.

Test Plan:
- 512-bit, size=0 -> nb=1; desc0: data=0, pad_here=1, pos=0, last=1.
- size=55 -> nb=1, pos=55, last. size=56 -> nb=2; desc0: data=56, pad pos=56, last=0; desc1: data=0, pad_here=0, last=1.
- size=80 (bitcoin header) -> nb=2; desc0: data=64, pad_here=0; desc1: data=16, pos=16, last. size=64 -> desc1: pad pos=0.
- CNT_W=8: size=16311 -> nb=255, 255 descriptors. size=16312 -> err_ovf pulse, 0 descriptors, req_ready back next cycle.
- size=120, blk_ready toggled randomly -> 3 descriptors in order, fields stable under stall. reset asserted mid-EMIT -> outputs at reset values next cycle.
- BLOCK_BITS=1024: size=111 -> nb=1; size=112 -> nb=2. With SHA_BLKSEQ_ABORT_EN, abort on desc1 of a 3-block request -> IDLE, no further blk_valid.
